// File: rtl/fir3_mac_seq.sv
// fir3_mac_seq: sequential 3-tap fixed-point FIR stage.
// One shared signed N x N multiplier is used over three cycles (MAC0..MAC2).
// The sum is scaled by an arithmetic right shift of F, then saturated to N bits.
// done and y_out are registered, so they appear the cycle after FIN.
module fir3_mac_seq #(
   parameter int N = 16,
   parameter int F = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] x_in,
   input  logic [N-1:0] coef_a0,
   input  logic [N-1:0] coef_a1,
   input  logic [N-1:0] coef_a2,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] y_out
);

   localparam int ACC_W = 2 * N + 2;

   // Saturation bounds, expressed at accumulator width.
   localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W - N + 1){1'b0}}, {(N - 1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W - N + 1){1'b1}}, {(N - 1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MAC0 = 3'd1,
      MAC1 = 3'd2,
      MAC2 = 3'd3,
      FIN  = 3'd4
   } state_t;

   state_t                   state_r;
   state_t                   state_s;
   logic signed [N-1:0]      x_cap_r;
   logic signed [N-1:0]      c0_r;
   logic signed [N-1:0]      c1_r;
   logic signed [N-1:0]      c2_r;
   logic signed [N-1:0]      x1_r;
   logic signed [N-1:0]      x2_r;
   logic signed [ACC_W-1:0]  acc_r;
   logic signed [N-1:0]      mul_a_s;
   logic signed [N-1:0]      mul_b_s;
   logic signed [2*N-1:0]    prod_s;

   // Scale by 2^-F (floor) and clamp into the signed N-bit range.
   function automatic logic [N-1:0] sat_fn(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] sh;
      sh = v >>> F;
      if (sh > MAX_V) begin
         sat_fn = MAX_V[N-1:0];
      end else if (sh < MIN_V) begin
         sat_fn = MIN_V[N-1:0];
      end else begin
         sat_fn = sh[N-1:0];
      end
   endfunction

   // Next-state logic for the MAC sequencer.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = MAC0;
            end else begin
               state_s = IDLE;
            end
         end
         MAC0:    state_s = MAC1;
         MAC1:    state_s = MAC2;
         MAC2:    state_s = FIN;
         FIN:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Operand select for the shared multiplier: one tap per MAC state.
   always_comb begin
      mul_a_s = '0;
      mul_b_s = '0;
      case (state_r)
         MAC0: begin
            mul_a_s = x_cap_r;
            mul_b_s = c0_r;
         end
         MAC1: begin
            mul_a_s = x1_r;
            mul_b_s = c1_r;
         end
         MAC2: begin
            mul_a_s = x2_r;
            mul_b_s = c2_r;
         end
         default: begin
            mul_a_s = '0;
            mul_b_s = '0;
         end
      endcase
   end

   assign prod_s = mul_a_s * mul_b_s;

   // State, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         x_cap_r <= '0;
         c0_r    <= '0;
         c1_r    <= '0;
         c2_r    <= '0;
         x1_r    <= '0;
         x2_r    <= '0;
         acc_r   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         y_out   <= '0;
      end else begin
         state_r <= state_s;
         busy    <= (state_s != IDLE);
         done    <= (state_r == FIN);
         case (state_r)
            IDLE: begin
               if (start) begin
                  x_cap_r <= x_in;
                  c0_r    <= coef_a0;
                  c1_r    <= coef_a1;
                  c2_r    <= coef_a2;
                  acc_r   <= '0;
               end
            end
            MAC0, MAC1, MAC2: begin
               acc_r <= acc_r + {{2{prod_s[2*N-1]}}, prod_s};
            end
            FIN: begin
               y_out <= sat_fn(acc_r);
               x2_r  <= x1_r;
               x1_r  <= x_cap_r;
            end
            default: begin
               acc_r <= acc_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir3_mac_seq.sv
// Self-checking bench for fir3_mac_seq: directed cases plus random samples
// compared against an arithmetic reference (floor-scaled, saturated FIR sum).
module tb_fir3_mac_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] x_in;
   logic [15:0] coef_a0;
   logic [15:0] coef_a1;
   logic [15:0] coef_a2;
   logic        busy;
   logic        done;
   logic [15:0] y_out;

   int compared   = 0;
   int mismatched = 0;

   // Reference history: last two accepted samples as signed integers.
   longint h1 = 0;
   longint h2 = 0;

   fir3_mac_seq #(.N(16), .F(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .x_in    (x_in),
      .coef_a0 (coef_a0),
      .coef_a1 (coef_a1),
      .coef_a2 (coef_a2),
      .busy    (busy),
      .done    (done),
      .y_out   (y_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // y = sat(floor((a0*x + a1*h1 + a2*h2) / 256)) in Q8.8.
   function automatic logic [15:0] ref_y(input longint x, input longint p1, input longint p2,
                                         input longint a0, input longint a1, input longint a2);
      longint s;
      logic [63:0] bits;
      s = a0 * x + a1 * p1 + a2 * p2;
      s = s >>> 8;
      if (s > 64'sd32767) s = 64'sd32767;
      else if (s < -64'sd32768) s = -64'sd32768;
      bits = s;
      return bits[15:0];
   endfunction

   function automatic longint sx(input logic [15:0] v);
      return longint'($signed(v));
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      h1 = 0;
      h2 = 0;
   endtask

   // One accepted sample; rej[0] pulses start in MAC1, rej[1] pulses it in FIN.
   task automatic run_sample(input logic [15:0] x, input logic [15:0] a0, input logic [15:0] a1,
                             input logic [15:0] a2, input logic [1:0] rej, input string tag);
      logic [15:0] exp;
      @(negedge clk);
      x_in    = x;
      coef_a0 = a0;
      coef_a1 = a1;
      coef_a2 = a2;
      start   = 1'b1;
      exp = ref_y(sx(x), h1, h2, sx(a0), sx(a1), sx(a2));
      h2 = h1;
      h1 = sx(x);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) begin
            coef_a0 = 16'($urandom);
            coef_a1 = 16'($urandom);
            coef_a2 = 16'($urandom);
         end
         x_in = 16'($urandom);
         if (k < 5) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_nodone"}, {31'd0, done}, 32'd0);
         end else begin
            check({tag, "_done"}, {31'd0, done}, 32'd1);
            check({tag, "_idle"}, {31'd0, busy}, 32'd0);
            check({tag, "_y"}, {16'd0, y_out}, {16'd0, exp});
         end
         start = ((k == 2) && rej[0]) || ((k == 4) && rej[1]);
      end
      @(negedge clk);
      check({tag, "_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_hold"}, {16'd0, y_out}, {16'd0, exp});
   endtask

   task automatic impulse(input string tag);
      run_sample(16'h0100, 16'h0100, 16'h0080, 16'h0040, 2'b00, {tag, "0"});
      check({tag, "0_abs"}, {16'd0, y_out}, 32'h0000_0100);
      run_sample(16'h0000, 16'h0100, 16'h0080, 16'h0040, 2'b00, {tag, "1"});
      check({tag, "1_abs"}, {16'd0, y_out}, 32'h0000_0080);
      run_sample(16'h0000, 16'h0100, 16'h0080, 16'h0040, 2'b00, {tag, "2"});
      check({tag, "2_abs"}, {16'd0, y_out}, 32'h0000_0040);
      run_sample(16'h0000, 16'h0100, 16'h0080, 16'h0040, 2'b00, {tag, "3"});
      check({tag, "3_abs"}, {16'd0, y_out}, 32'h0000_0000);
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      x_in    = 16'h0000;
      coef_a0 = 16'h0000;
      coef_a1 = 16'h0000;
      coef_a2 = 16'h0000;

      // Reset state
      do_reset();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_y", {16'd0, y_out}, 32'd0);

      // Unit gain, latency and busy width
      run_sample(16'h0280, 16'h0100, 16'h0000, 16'h0000, 2'b00, "unity");
      check("unity_abs", {16'd0, y_out}, 32'h0000_0280);

      // Impulse response from zero history
      do_reset();
      impulse("imp");

      // Saturation
      do_reset();
      run_sample(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 2'b00, "satp");
      check("satp_abs", {16'd0, y_out}, 32'h0000_7FFF);
      do_reset();
      run_sample(16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 2'b00, "satn");
      check("satn_abs", {16'd0, y_out}, 32'h0000_8000);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         run_sample(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 2'b00, "sat3");
      end
      check("sat3_abs", {16'd0, y_out}, 32'h0000_7FFF);

      // Truncation toward minus infinity
      do_reset();
      run_sample(16'hFFFF, 16'h0080, 16'h0000, 16'h0000, 2'b00, "trn");
      check("trn_abs", {16'd0, y_out}, 32'h0000_FFFF);
      do_reset();
      run_sample(16'h0001, 16'h0080, 16'h0000, 16'h0000, 2'b00, "trp");
      check("trp_abs", {16'd0, y_out}, 32'h0000_0000);

      // Starts while busy are ignored and never enter the history
      do_reset();
      run_sample(16'h0100, 16'h0100, 16'h0000, 16'h0000, 2'b11, "rej");
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("rej_nodone", {31'd0, done}, 32'd0);
      end
      run_sample(16'h0000, 16'h0000, 16'h0100, 16'h0100, 2'b00, "rej_next");
      check("rej_next_abs", {16'd0, y_out}, 32'h0000_0100);

      // Reset in MAC2 aborts the computation and clears history
      run_sample(16'h0300, 16'h0100, 16'h0000, 16'h0000, 2'b00, "pre_abort");
      @(negedge clk);
      x_in    = 16'h0200;
      coef_a0 = 16'h0100;
      coef_a1 = 16'h0100;
      coef_a2 = 16'h0100;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      h1 = 0;
      h2 = 0;
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_y", {16'd0, y_out}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_nodone", {31'd0, done}, 32'd0);
      end
      impulse("imp2");

      // Random samples, coefficients and busy-time start pulses
      for (int i = 0; i < 40; i++) begin
         logic [15:0] rx;
         logic [15:0] r0;
         logic [15:0] r1;
         logic [15:0] r2;
         rx = 16'($urandom);
         r0 = 16'($urandom);
         r1 = 16'($urandom);
         r2 = 16'($urandom);
         if (i % 5 == 0) rx = ($urandom_range(1) == 1) ? 16'h7FFF : 16'h8000;
         if (i % 3 == 0) begin
            r0 = {{4{r0[15]}}, r0[11:0]};
            r1 = {{4{r1[15]}}, r1[11:0]};
            r2 = {{4{r2[15]}}, r2[11:0]};
         end
         run_sample(rx, r0, r1, r2, 2'($urandom), "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
